instr_fetch_router: RTL and testbench
=====================================

# instr_fetch_router

Routes the core's instruction-fetch requests to either the boot ROM or the main SRAM by address range and returns the responses to the core in order. It sits directly upstream of the boot ROM, which has fixed one-cycle read latency and is always ready, and alongside the variable-latency SRAM port. The router generates the core-side grant and valid signals, tracks outstanding fetches, and answers unmapped addresses with an error response.

## Interface
- RomBase, 32'h1A00_0000, boot ROM region base
- RomSize, 32'h0000_1000, boot ROM region size in bytes
- MemBase, 32'h1C00_0000, SRAM region base
- MemSize, 32'h0008_0000, SRAM region size in bytes
- MaxOutstanding, 2, maximum number of granted fetches without a response; must be at least 1
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- instr_req_i  in  1  core fetch request
- instr_addr_i  in  32  core fetch byte address
- instr_gnt_o  out  1  request accepted in this cycle
- instr_rvalid_o  out  1  response valid
- instr_rdata_o  out  32  response data
- instr_err_o  out  1  response is an error, qualified by rvalid
- rom_req_o  out  1  ROM read strobe
- rom_addr_o  out  32  ROM byte address, equal to instr_addr_i
- rom_rdata_i  in  32  ROM data, valid the cycle after rom_req_o
- mem_req_o  out  1  SRAM request
- mem_addr_o  out  32  SRAM byte address, equal to instr_addr_i
- mem_gnt_i  in  1  SRAM grant
- mem_rvalid_i  in  1  SRAM response valid
- mem_rdata_i  in  32  SRAM response data

## Operation
- Address decode (combinational, 32-bit unsigned):
  - The target is ROM if (addr - RomBase) < RomSize.
  - Otherwise the target is MEM if (addr - MemBase) < MemSize.
  - Otherwise the target is ERR. If the regions overlap, ROM takes priority.
- State:
  - out_cnt: 0..MaxOutstanding.
  - cur_tgt: one of {NONE, ROM, MEM, ERR}.
  - rom_pend and err_pend: single-bit response-due flags.
- allowed = (out_cnt < MaxOutstanding) && (out_cnt == 0 || tgt == cur_tgt). Switching targets always waits for full drain, so no reorder buffering is needed.
- Request and grant by target:
  - ROM: rom_req_o = instr_req_i && allowed; instr_gnt_o = same.
  - MEM: mem_req_o = instr_req_i && allowed; instr_gnt_o = mem_gnt_i && mem_req_o.
  - ERR: instr_gnt_o = instr_req_i && allowed; no downstream request.
- On grant, cur_tgt takes the request's target.
- Responses:
  - rom_pend=1 gives rvalid=1 with rdata=rom_rdata_i and err=0.
  - err_pend=1 gives rvalid=1 with rdata=0 and err=1.
  - MEM: rvalid = mem_rvalid_i && out_cnt>0 && cur_tgt==MEM, with rdata=mem_rdata_i and err=0.
- Counter update: out_cnt += gnt − rvalid. A grant and a response in the same cycle leave it unchanged.
- A stray mem_rvalid_i while out_cnt==0 or cur_tgt!=MEM is dropped and does not underflow the counter.
- When out_cnt reaches 0, cur_tgt stays at its last value but no longer restricts the next grant.
- instr_rdata_o is 0 whenever instr_rvalid_o=0.

## Timing
- Reset state: out_cnt=0, cur_tgt=NONE, rom_pend=0, err_pend=0.
- Outputs during reset: instr_rvalid_o=0, instr_err_o=0, instr_rdata_o=0. instr_gnt_o, rom_req_o and mem_req_o are 0 unless instr_req_i=1.
- The grant is combinational in the request cycle. The core holds addr stable until granted.
- ROM and ERR responses arrive exactly 1 cycle after the grant. Back-to-back ROM grants give a response every cycle.
- MEM response latency equals the SRAM latency, passed through with zero added cycles.
- With MaxOutstanding=2 there is no ROM-throughput loss, because a retirement frees a slot in the following cycle.
- If reset asserts mid-operation, all in-flight fetches are abandoned. Late SRAM responses after reset are dropped by the out_cnt==0 rule.

## Configuration
- INSTR_ROUTER_ERR_RESP_EN defined:
  - Unmapped addresses take the ERR target as described.
- INSTR_ROUTER_ERR_RESP_EN undefined:
  - There is no ERR target; unmapped addresses route to MEM.
  - instr_err_o is tied 0 and the err_pend logic is removed.

## Test plan
- Reset, then fetch 0x1A00_0000 and 0x1A00_0004 back-to-back with ROM words 0x0000_10B7 and 0x0800_8067 → gnt in cycles 1 and 2, rvalid in cycles 2 and 3 with those words, err=0.
- Fetch 0x1C00_0080 with mem_gnt_i low for 2 cycles, then high, and rvalid 3 cycles later with data 0xDEAD_BEEF → gnt on the third request cycle, rdata 0xDEAD_BEEF, out_cnt returns to 0.
- MEM fetch outstanding, then a ROM fetch to 0x1A00_0008 → ROM gnt withheld until the MEM rvalid, ROM gnt the same cycle or later, responses in order.
- Fetch 0x0000_0000 → with the macro: gnt, then rvalid=1, err=1, rdata=0 next cycle. Without the macro: routed to mem_req_o.
- Two MEM grants pending, third request → gnt=0 until an rvalid. Assert rst_i with one outstanding, then inject mem_rvalid_i → instr_rvalid_o stays 0.

Source files
------------

// File: rtl/instr_fetch_router.sv
// instr_fetch_router
// Routes core instruction fetches to the boot ROM or the SRAM by address
// range and returns the responses in order. Targets are never mixed while
// fetches are in flight, so ordering needs no reorder buffer.
// Optional feature macro: INSTR_ROUTER_ERR_RESP_EN. When defined, unmapped
// addresses get a one-cycle error response. When undefined, they go to SRAM.
module instr_fetch_router #(
    parameter logic [31:0] RomBase        = 32'h1A00_0000,
    parameter logic [31:0] RomSize        = 32'h0000_1000,
    parameter logic [31:0] MemBase        = 32'h1C00_0000,
    parameter logic [31:0] MemSize        = 32'h0008_0000,
    parameter int          MaxOutstanding = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,
    output logic        rom_req_o,
    output logic [31:0] rom_addr_o,
    input  logic [31:0] rom_rdata_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int              CntW   = $clog2(MaxOutstanding + 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);

    typedef enum logic [1:0] {
        TGT_NONE = 2'd0,
        TGT_ROM  = 2'd1,
        TGT_MEM  = 2'd2,
        TGT_ERR  = 2'd3
    } tgt_e;

    tgt_e            r_cur_tgt;
    tgt_e            w_tgt;
    logic [CntW-1:0] r_out_cnt;
    logic [CntW-1:0] w_out_cnt_next;
    logic            r_rom_pend;
    logic            w_err_pend;
    logic            w_allowed;
    logic            w_gnt;
    logic            w_rom_req;
    logic            w_mem_req;
    logic            w_mem_rvalid;
    logic            w_rvalid;

    // Address decode; ROM wins if the two regions ever overlap.
    always_comb begin
        if ((instr_addr_i - RomBase) < RomSize) begin
            w_tgt = TGT_ROM;
        end else if ((instr_addr_i - MemBase) < MemSize) begin
            w_tgt = TGT_MEM;
        end else begin
`ifdef INSTR_ROUTER_ERR_RESP_EN
            w_tgt = TGT_ERR;
`else
            w_tgt = TGT_MEM;
`endif
        end
    end

    // A slot must be free, and a target switch waits for a full drain.
    assign w_allowed = (r_out_cnt < MaxCnt) &&
                       ((r_out_cnt == '0) || (w_tgt == r_cur_tgt));

    // Downstream strobes and core grant; SRAM grants only when it accepts.
    always_comb begin
        w_rom_req = 1'b0;
        w_mem_req = 1'b0;
        w_gnt     = 1'b0;
        case (w_tgt)
            TGT_ROM: begin
                w_rom_req = instr_req_i && w_allowed;
                w_gnt     = w_rom_req;
            end
            TGT_MEM: begin
                w_mem_req = instr_req_i && w_allowed;
                w_gnt     = w_mem_req && mem_gnt_i;
            end
            TGT_ERR: begin
                w_gnt     = instr_req_i && w_allowed;
            end
            default: begin
                w_gnt     = 1'b0;
            end
        endcase
    end

    assign rom_req_o   = w_rom_req;
    assign mem_req_o   = w_mem_req;
    assign instr_gnt_o = w_gnt;
    assign rom_addr_o  = instr_addr_i;
    assign mem_addr_o  = instr_addr_i;

    // SRAM responses only count while SRAM fetches are actually in flight;
    // anything else (stray or post-reset) is dropped.
    assign w_mem_rvalid = mem_rvalid_i && (r_out_cnt != '0) && (r_cur_tgt == TGT_MEM);
    assign w_rvalid     = r_rom_pend || w_err_pend || w_mem_rvalid;

    // Response mux; data is forced to zero when no response is presented.
    always_comb begin
        instr_rdata_o = 32'h0;
        if (r_rom_pend) begin
            instr_rdata_o = rom_rdata_i;
        end else if (w_mem_rvalid) begin
            instr_rdata_o = mem_rdata_i;
        end
    end

    assign instr_rvalid_o = w_rvalid;
    assign instr_err_o    = w_err_pend;

    // Outstanding count: a grant and a retirement in one cycle cancel out.
    assign w_out_cnt_next = r_out_cnt + CntW'(w_gnt) - CntW'(w_rvalid);

    // Tracking state; cur_tgt keeps its last value once the count drains.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_out_cnt  <= '0;
            r_cur_tgt  <= TGT_NONE;
            r_rom_pend <= 1'b0;
        end else begin
            r_out_cnt  <= w_out_cnt_next;
            r_rom_pend <= w_gnt && (w_tgt == TGT_ROM);
            if (w_gnt) begin
                r_cur_tgt <= w_tgt;
            end
        end
    end

`ifdef INSTR_ROUTER_ERR_RESP_EN
    logic r_err_pend;

    // Error response is due exactly one cycle after an unmapped grant.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_err_pend <= 1'b0;
        end else begin
            r_err_pend <= w_gnt && (w_tgt == TGT_ERR);
        end
    end

    assign w_err_pend = r_err_pend;
`else
    assign w_err_pend = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_router.sv
// Randomized bench for instr_fetch_router: a core, a 1-cycle ROM and a
// variable-latency SRAM are modelled here; an in-order queue of expected
// responses (built from the address map) is the reference.
module tb_instr_fetch_router;

    localparam logic [31:0] ROM_BASE = 32'h1A00_0000;
    localparam logic [31:0] ROM_SIZE = 32'h0000_1000;
    localparam logic [31:0] MEM_BASE = 32'h1C00_0000;
    localparam logic [31:0] MEM_SIZE = 32'h0008_0000;
    localparam int          MAX_OUT  = 2;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        instr_req_i = 1'b0;
    logic [31:0] instr_addr_i = '0;
    logic        instr_gnt_o;
    logic        instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        instr_err_o;
    logic        rom_req_o;
    logic [31:0] rom_addr_o;
    logic [31:0] rom_rdata_i = '0;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;

    instr_fetch_router #(
        .RomBase(ROM_BASE), .RomSize(ROM_SIZE),
        .MemBase(MEM_BASE), .MemSize(MEM_SIZE),
        .MaxOutstanding(MAX_OUT)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
        .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
        .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
        .rom_req_o(rom_req_o), .rom_addr_o(rom_addr_o), .rom_rdata_i(rom_rdata_i),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
        int          tgt;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        int          ready;
    } sram_t;

    resp_t       expq[$];
    sram_t       sramq[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          n_rsp = 0;
    int          last_tgt = -1;
    bit          cur_req = 1'b0;
    logic [31:0] cur_addr = '0;
    bit          fixed_due = 1'b0;
    bit          prev_rom_req = 1'b0;
    logic [31:0] prev_rom_addr = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ~a + 32'h0101_0101;
    endfunction

    // 0 = ROM, 1 = MEM, 2 = ERR
    function automatic int tgt_of(input logic [31:0] a);
        int t;
        if (a >= ROM_BASE && a < ROM_BASE + ROM_SIZE) t = 0;
        else if (a >= MEM_BASE && a < MEM_BASE + MEM_SIZE) t = 1;
        else begin
`ifdef INSTR_ROUTER_ERR_RESP_EN
            t = 2;
`else
            t = 1;
`endif
        end
        return t;
    endfunction

    function automatic logic [31:0] pick_addr();
        logic [31:0] a;
        case ($urandom_range(0, 9))
            0, 1, 2: a = ROM_BASE + ($urandom_range(0, 1023) << 2);
            3, 4, 5: a = MEM_BASE + ($urandom_range(0, 32'h1FFFF) << 2);
            6, 7: begin
                case ($urandom_range(0, 7))
                    0: a = ROM_BASE - 32'd4;
                    1: a = ROM_BASE + ROM_SIZE - 32'd4;
                    2: a = ROM_BASE + ROM_SIZE;
                    3: a = MEM_BASE - 32'd4;
                    4: a = MEM_BASE;
                    5: a = MEM_BASE + MEM_SIZE - 32'd4;
                    6: a = MEM_BASE + MEM_SIZE;
                    default: a = 32'hFFFF_FFFC;
                endcase
            end
            8: a = 32'h0;
            default: a = $urandom & 32'hFFFF_FFFC;
        endcase
        return a;
    endfunction

    // One clock: drive all inputs, then check outputs against the model.
    task automatic do_cycle(input bit allow_req);
        bit    legit_mem;
        bit    allowed;
        bit    exp_rom_req;
        bit    exp_mem_req;
        bit    exp_gnt;
        bit    exp_rv;
        int    tgt;
        resp_t e;
        @(posedge clk);
        #1;
        cyc++;
        rom_rdata_i = prev_rom_req ? rom_word(prev_rom_addr) : $urandom;
        if (!cur_req && allow_req && $urandom_range(0, 3) != 0) begin
            cur_req  = 1'b1;
            cur_addr = pick_addr();
        end
        instr_req_i  = cur_req;
        instr_addr_i = cur_req ? cur_addr : $urandom;
        mem_gnt_i    = ($urandom_range(0, 2) != 0);
        legit_mem    = 1'b0;
        if (sramq.size() > 0 && sramq[0].ready <= cyc && $urandom_range(0, 3) != 0) begin
            legit_mem    = 1'b1;
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = mem_word(sramq[0].addr);
            void'(sramq.pop_front());
        end else if (sramq.size() == 0 && (expq.size() == 0 || last_tgt != 1) &&
                     $urandom_range(0, 7) == 0) begin
            mem_rvalid_i = 1'b1;           // stray response, must be ignored
            mem_rdata_i  = $urandom;
        end else begin
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = $urandom;
        end
        #1;
        tgt         = tgt_of(cur_addr);
        allowed     = (expq.size() < MAX_OUT) && (expq.size() == 0 || tgt == last_tgt);
        exp_rom_req = cur_req && allowed && tgt == 0;
        exp_mem_req = cur_req && allowed && tgt == 1;
        exp_gnt     = exp_rom_req || (exp_mem_req && mem_gnt_i) || (cur_req && allowed && tgt == 2);
        check_eq("gnt", instr_gnt_o, exp_gnt);
        check_eq("rom_req", rom_req_o, exp_rom_req);
        check_eq("mem_req", mem_req_o, exp_mem_req);
        if (exp_rom_req) check_eq("rom_addr", rom_addr_o, cur_addr);
        if (exp_mem_req) check_eq("mem_addr", mem_addr_o, cur_addr);
        exp_rv = fixed_due || legit_mem;
        check_eq("rvalid", instr_rvalid_o, exp_rv);
        if (exp_rv && expq.size() > 0) begin
            e = expq.pop_front();
            check_eq("rdata", instr_rdata_o, e.data);
            check_eq("err", instr_err_o, e.err);
            n_rsp++;
            $display("rsp %0d cyc %0d tgt %0d addr %h data %h err %0d",
                     n_rsp, cyc, e.tgt, e.addr, instr_rdata_o, instr_err_o);
        end else if (!exp_rv) begin
            check_eq("rdata_idle", instr_rdata_o, 32'h0);
            check_eq("err_idle", instr_err_o, 1'b0);
        end
        fixed_due     = 1'b0;
        prev_rom_req  = exp_rom_req;
        prev_rom_addr = cur_addr;
        if (exp_gnt) begin
            e.addr = cur_addr;
            e.tgt  = tgt;
            e.err  = (tgt == 2);
            e.data = (tgt == 0) ? rom_word(cur_addr) : (tgt == 1) ? mem_word(cur_addr) : 32'h0;
            expq.push_back(e);
            last_tgt = tgt;
            cur_req  = 1'b0;
            if (tgt == 1) sramq.push_back('{addr: cur_addr, ready: cyc + int'($urandom_range(1, 4))});
            else fixed_due = 1'b1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_rvalid"}, instr_rvalid_o, 1'b0);
        check_eq({tag, "_err"}, instr_err_o, 1'b0);
        check_eq({tag, "_rdata"}, instr_rdata_o, 32'h0);
        check_eq({tag, "_gnt"}, instr_gnt_o, 1'b0);
    endtask

    initial begin
        #12;
        check_reset_outputs("por");
        @(posedge clk);
        #1;
        rst_i = 1'b0;

        for (int i = 0; i < 1500; i++) do_cycle(1'b1);

        // Mid-operation reset with an SRAM fetch in flight.
        for (int i = 0; i < 300 && sramq.size() == 0; i++) do_cycle(1'b1);
        check_eq("mem_inflight_at_rst", sramq.size() > 0, 1'b1);
        @(posedge clk);
        #1;
        instr_req_i  = 1'b0;
        mem_rvalid_i = 1'b0;
        rst_i        = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        expq.delete();
        cur_req      = 1'b0;
        fixed_due    = 1'b0;
        prev_rom_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            instr_req_i  = 1'b0;
            mem_rvalid_i = 1'b1;
            if (sramq.size() > 0) begin
                mem_rdata_i = mem_word(sramq[0].addr);
                void'(sramq.pop_front());
            end else begin
                mem_rdata_i = $urandom;
            end
            #1;
            check_eq("late_rvalid", instr_rvalid_o, 1'b0);
            check_eq("late_rdata", instr_rdata_o, 32'h0);
        end
        sramq.delete();
        mem_rvalid_i = 1'b0;

        for (int i = 0; i < 1500; i++) do_cycle(1'b1);
        for (int i = 0; i < 60; i++) do_cycle(1'b0);
        check_eq("drained", expq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
